// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agents.
package arb_pkg;

   localparam int unsigned NUM_REQ = 4;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StXfer,
      StRel
   } req_state_e;

endpackage

// File: rtl/arb_req_fifo.sv
// Synchronous circular FIFO with occupancy count; a full FIFO refuses a push even alongside a pop.
module arb_req_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_i,
   input  logic [DATA_W-1:0]           push_data_i,
   input  logic                        pop_i,
   output logic [DATA_W-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o,
   output logic                        full_o,
   output logic                        empty_o
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              push_acc, pop_acc;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign push_acc = push_i & ~full_o;
   assign pop_acc  = pop_i & ~empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for the req/gnt arbiter handshake: buffers producer words, requests
// the bus, streams bounded bursts on grant and flags starvation and illegal grants.
module arb_requester
   import arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ready,
   input  logic              gnt,
   output logic              req,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              starved,
   output logic              protocol_err
);

   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

   req_state_e        state_q, state_d;
   logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic              starved_q, starved_d;
   logic              perr_q, perr_d;

   logic [DATA_W-1:0] fifo_head;
   logic [CntW-1:0]   fifo_count;
   logic              fifo_full, fifo_empty;
   logic              push_acc, last_word;

   arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push_valid),
      .push_data_i (push_data),
      .pop_i       (bus_valid),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign push_ready   = ~fifo_full;
   assign push_acc     = push_valid & ~fifo_full;
   assign last_word    = (fifo_count == CntW'(1));
   assign req          = (state_q == StReq) | (state_q == StXfer);
   assign bus_valid    = (state_q == StXfer) & gnt & ~fifo_empty;
   assign bus_data     = bus_valid ? fifo_head : '0;
   assign starved      = starved_q;
   assign protocol_err = perr_q;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      wait_cnt_d = wait_cnt_q;
      starved_d  = starved_q;
      perr_d     = perr_q;
      case (state_q)
         StIdle: begin
            if (gnt)         perr_d  = 1'b1;
            if (!fifo_empty) state_d = StReq;
         end
         StReq: begin
            if (gnt) begin
               state_d    = StXfer;
               wait_cnt_d = '0;
               starved_d  = 1'b0;
               beat_cnt_d = '0;
            end else begin
               if (wait_cnt_q != WaitW'(TIMEOUT)) wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_d == WaitW'(TIMEOUT)) starved_d = 1'b1;
            end
         end
         StXfer: begin
            // gnt low is a preemption: hold req and keep beat_cnt for the resume.
            if (bus_valid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if ((beat_cnt_q == BeatW'(MAX_BURST - 1)) || (last_word && !push_acc)) begin
                  state_d = StRel;
               end
            end else if (gnt) begin
               state_d = StRel;
            end
         end
         StRel: begin
            if (gnt) perr_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         beat_cnt_q <= '0;
         wait_cnt_q <= '0;
         starved_q  <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         starved_q  <= starved_d;
         perr_q     <= perr_d;
      end
   end

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: directed scenarios plus random traffic checked against
// a word-queue reference model of the requester behaviour.
module tb_arb_requester;

   localparam int DW        = 8;
   localparam int DEPTH     = 4;
   localparam int MAX_BURST = 4;
   localparam int TIMEOUT   = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push_valid = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          push_ready;
   logic          gnt = 1'b0;
   logic          req;
   logic          bus_valid;
   logic [DW-1:0] bus_data;
   logic          starved;
   logic          protocol_err;

   arb_requester #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .MAX_BURST (MAX_BURST),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .push_valid   (push_valid),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .gnt          (gnt),
      .req          (req),
      .bus_valid    (bus_valid),
      .bus_data     (bus_data),
      .starved      (starved),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 waiting for grant, 2 sending, 3 release gap.
   int m_phase = 0, m_cnt = 0, m_sent = 0, m_wait = 0;
   bit m_starved = 0, m_perr = 0;
   logic [DW-1:0] sb_q[$];

   bit exp_req, exp_pr, exp_bv, exp_st, exp_pe;
   bit last_acc, last_beat;
   int cyc = 0;
   int n_vec = 0, n_err = 0;

   function automatic bit mreq();
      return (m_phase == 1) || (m_phase == 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit pv, input logic [DW-1:0] pd, input bit g);
      bit acc, beat;
      @(negedge clk);
      rst = r; push_valid = pv; push_data = pd; gnt = g;
      cyc++;
      #1;
      acc  = pv && (m_cnt < DEPTH);
      beat = (m_phase == 2) && g && (m_cnt > 0);
      exp_req = mreq();
      exp_pr  = (m_cnt < DEPTH);
      exp_bv  = beat;
      exp_st  = m_starved;
      exp_pe  = m_perr;
      last_acc  = acc && !r;
      last_beat = beat;
      if (r) begin
         m_phase = 0; m_cnt = 0; m_sent = 0; m_wait = 0; m_starved = 0; m_perr = 0;
         sb_q.delete();
      end else begin
         if (acc) sb_q.push_back(pd);
         case (m_phase)
            0: begin
               if (g) m_perr = 1;
               if (m_cnt > 0) m_phase = 1;
            end
            1: begin
               if (g) begin
                  m_phase = 2; m_wait = 0; m_starved = 0; m_sent = 0;
               end else begin
                  if (m_wait < TIMEOUT) m_wait++;
                  if (m_wait == TIMEOUT) m_starved = 1;
               end
            end
            2: begin
               if (beat) begin
                  m_sent++;
                  if (m_sent == MAX_BURST || (m_cnt == 1 && !acc)) m_phase = 3;
               end else if (g) begin
                  m_phase = 3;
               end
            end
            default: begin
               if (g) m_perr = 1;
               m_phase = 0;
            end
         endcase
         m_cnt = m_cnt + int'(acc) - int'(beat);
      end
   endtask

   // Monitor: compares control outputs each cycle and pops the scoreboard on every beat.
   always begin
      @(negedge clk);
      #2;
      if (cyc >= 2) begin
         chk("req", req, exp_req);
         chk("push_ready", push_ready, exp_pr);
         chk("bus_valid", bus_valid, exp_bv);
         chk("starved", starved, exp_st);
         chk("protocol_err", protocol_err, exp_pe);
         if (bus_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("bus_data_unexpected", bus_data, 32'hdead);
            else chk("bus_data", bus_data, sb_q.pop_front());
         end else begin
            chk("bus_data_idle", bus_data, 0);
         end
      end
   end

   task automatic do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
   endtask

   initial begin
      int beats, guard;
      logic [DW-1:0] words [6];
      do_reset();

      // Two words, grant follows req.
      step(0, 1, 8'hA1, 0);
      step(0, 1, 8'hB2, 0);
      repeat (8) step(0, 0, 0, mreq());
      chk("t1_empty_ready", push_ready, 1);

      // Six words into a 4-deep FIFO; producer holds each word until accepted.
      do_reset();
      for (int i = 0; i < 6; i++) words[i] = 8'h10 + 8'(i);
      for (int i = 0; i < 6; i++) begin
         guard = 0;
         do begin
            step(0, 1, words[i], (cyc % 20 > 8) ? mreq() : 1'b0);
            guard++;
         end while (!last_acc && guard < 60);
         if (!last_acc) chk("t2_push_timeout", guard, 0);
      end
      repeat (16) step(0, 0, 0, mreq());

      // Starvation: 15 cycles in request without grant.
      do_reset();
      step(0, 1, 8'h5C, 0);
      step(0, 0, 0, 0);
      repeat (TIMEOUT - 1) step(0, 0, 0, 0);
      #2 chk("t3_not_yet_starved", starved, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      #2 chk("t3_starved_set", starved, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      #2 chk("t3_starved_clr", starved, 0);
      chk("t3_first_beat", bus_valid, 1);
      repeat (4) step(0, 0, 0, mreq());

      // Preemption after the first of three beats.
      do_reset();
      step(0, 1, 8'h31, 0);
      step(0, 1, 8'h32, 0);
      step(0, 1, 8'h33, 0);
      beats = 0; guard = 0;
      while (beats < 1 && guard < 20) begin
         step(0, 0, 0, mreq());
         beats += int'(last_beat); guard++;
      end
      step(0, 0, 0, 0);
      #2 chk("t4_req_held", req, 1);
      step(0, 0, 0, 0);
      repeat (8) step(0, 0, 0, mreq());
      chk("t4_drained", sb_q.size(), 0);

      // Grant while idle.
      do_reset();
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      #2 chk("t5_perr_set", protocol_err, 1);
      repeat (3) step(0, 0, 0, 0);
      #2 chk("t5_perr_sticky", protocol_err, 1);

      // Reset mid-burst after two beats.
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0);
      beats = 0; guard = 0;
      while (beats < 2 && guard < 20) begin
         step(0, 0, 0, mreq());
         beats += int'(last_beat); guard++;
      end
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      #2 chk("t6_req_low", req, 0);
      chk("t6_ready", push_ready, 1);
      repeat (6) step(0, 0, 0, 1'b0);

      // Random traffic with an arbiter that usually grants and rarely misbehaves.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit r, g;
         r = ($urandom % 200) == 0;
         if (r) g = 0;
         else if (mreq()) g = ($urandom % 100) < 65;
         else g = ($urandom % 100) < 2;
         step(r, $urandom % 2, DW'($urandom), g);
      end
      repeat (2) step(0, 0, 0, 0);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
